histogram_compressor: RTL and testbench
=======================================

HISTOGRAM_COMPRESSOR -- requirements
Module: histogram_compressor

Interface
REQ-001 SHALL have parameter STREAM_LENGTH, default 128, meaning the number of bit-pairs per histogram.
REQ-002 SHALL have parameter COUNTER_WIDTH, default $clog2(STREAM_LENGTH+1), meaning the width of each bin count.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port start_compress, input, 1 bit: begins a new histogram.
REQ-006 SHALL have ports stream_a and stream_b, input, 1 bit each: the incoming bit-pair.
REQ-007 SHALL have port valid_in, input, 1 bit: qualifies stream_a and stream_b.
REQ-008 SHALL have ports count_00, count_01, count_10 and count_11, output, COUNTER_WIDTH each: bin totals indexed {a,b}.
REQ-009 SHALL have port hist_valid, output, 1 bit: the counts are complete and stable.
REQ-010 SHALL have port hist_ready, input, 1 bit: the downstream decompressor accepts the counts.
REQ-011 SHALL have port compress_done, output, 1 bit: one-cycle pulse on handshake completion.
REQ-012 SHALL have port busy, output, 1 bit: high in ACCUM or HOLD.
REQ-013 SHALL have port drop_err, output, 1 bit: sticky flag; a valid_in was ignored.

Function
REQ-014 SHALL implement FSM states IDLE, ACCUM and HOLD; reset state IDLE.
REQ-015 IDLE: start_compress=1 SHALL clear all four bins and the sample counter, then enter ACCUM next cycle; valid_in in that start cycle is not counted.
REQ-016 ACCUM: each cycle with valid_in=1 SHALL increment exactly one bin, selected by {stream_a,stream_b}, and the sample counter by 1.
REQ-017 ACCUM: when the accepted sample makes the counter equal STREAM_LENGTH, SHALL enter HOLD next cycle; hist_valid rises that cycle (1-cycle latency after the last sample).
REQ-018 HOLD: hist_valid=1 and the counts SHALL hold constant until hist_ready=1; on the hist_ready edge, next state is IDLE, hist_valid falls, and compress_done pulses high for exactly 1 cycle.
REQ-019 The counts SHALL remain readable in IDLE until the next start_compress.
REQ-020 valid_in=1 in IDLE or HOLD SHALL be ignored and SHALL set drop_err; drop_err SHALL clear only on reset or an accepted start_compress.
REQ-021 start_compress in ACCUM or HOLD SHALL be ignored, with no restart.
REQ-022 hist_ready while not in HOLD SHALL have no effect.
REQ-023 The sum of the four bins SHALL always equal the sample counter, and no bin SHALL exceed STREAM_LENGTH, so no wrap is possible.
REQ-024 The sample counter SHALL be COUNTER_WIDTH bits wide.
REQ-025 Bin increments SHALL be zero-extended and unsigned.
REQ-026 A STREAM_LENGTH of 1 SHALL give ACCUM lasting until the single valid sample, then HOLD.

Reset
REQ-027 While rst=1, the block SHALL immediately force state=IDLE, all counts=0, sample counter=0, hist_valid=0, compress_done=0, busy=0 and drop_err=0.
REQ-028 Reset asserted mid-ACCUM or mid-HOLD SHALL discard the partial histogram; no compress_done SHALL be generated.

Structure
REQ-029 A shared package histogram_pkg SHALL hold the STREAM_LENGTH default, the COUNTER_WIDTH derivation, the bin codes BIN_00, BIN_01, BIN_10 and BIN_11 (= {a,b}), and the FSM state encoding; the decompressor SHALL reuse it.
REQ-030 SHALL contain one sub-module, hist_bin_counter (clear, enable, COUNTER_WIDTH count), instanced four times.

Verification (bench with STREAM_LENGTH=8)
REQ-031 Start, then 8 valid pairs 00,01,10,11,11,10,01,00 -> counts 2/2/2/2, hist_valid 1 cycle after the 8th pair.
REQ-032 Start, then 8 pairs all 11 with valid_in gaps of 3 cycles -> count_11=8, others 0, busy high throughout.
REQ-033 In HOLD, hist_ready low for 5 cycles then high -> counts stable for all 5 cycles; compress_done high for 1 cycle; state IDLE.
REQ-034 valid_in=1 in IDLE, then start -> drop_err=1 before start, 0 after start; start during ACCUM -> ignored, count totals unchanged.
REQ-035 rst pulse after 5 samples -> all outputs 0 immediately; a new start plus 8 pairs 10 -> count_10=8.
REQ-036 Loopback with histogram_decompressor, STREAM_LENGTH=8, input counts 3/1/0/4 -> decompressed stream recompresses to 3/1/0/4.

Source files
------------

// File: rtl/histogram_pkg.sv
// Shared definitions for the histogram compressor/decompressor pair:
// default sizing, bin codes indexed {a,b}, and the FSM state encoding.
package histogram_pkg;

    localparam int STREAM_LENGTH_DEFAULT = 128;

    localparam logic [1:0] BIN_00 = 2'b00;
    localparam logic [1:0] BIN_01 = 2'b01;
    localparam logic [1:0] BIN_10 = 2'b10;
    localparam logic [1:0] BIN_11 = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } hist_state_e;

    // A bin can reach the full stream length, so it needs one extra code point.
    function automatic int counter_width(input int stream_length);
        return $clog2(stream_length + 1);
    endfunction

endpackage

// File: rtl/hist_bin_counter.sv
// One histogram bin: clears on request, otherwise counts up by one when enabled.
module hist_bin_counter
    import histogram_pkg::*;
#(
    parameter int COUNTER_WIDTH = counter_width(STREAM_LENGTH_DEFAULT)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     enable,
    output logic [COUNTER_WIDTH-1:0] count
);

    logic [COUNTER_WIDTH-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= count_reg + COUNTER_WIDTH'(1);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/histogram_compressor.sv
// Accumulates a fixed-length stream of bit-pairs into four bin counts and
// holds them for a valid/ready handshake with the downstream decompressor.
module histogram_compressor
    import histogram_pkg::*;
#(
    parameter int STREAM_LENGTH = STREAM_LENGTH_DEFAULT,
    parameter int COUNTER_WIDTH = counter_width(STREAM_LENGTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_compress,
    input  logic                     stream_a,
    input  logic                     stream_b,
    input  logic                     valid_in,
    output logic [COUNTER_WIDTH-1:0] count_00,
    output logic [COUNTER_WIDTH-1:0] count_01,
    output logic [COUNTER_WIDTH-1:0] count_10,
    output logic [COUNTER_WIDTH-1:0] count_11,
    output logic                     hist_valid,
    input  logic                     hist_ready,
    output logic                     compress_done,
    output logic                     busy,
    output logic                     drop_err
);

    localparam logic [COUNTER_WIDTH-1:0] LAST_IDX = COUNTER_WIDTH'(STREAM_LENGTH - 1);

    hist_state_e              state_reg;
    hist_state_e              state_next;
    logic [COUNTER_WIDTH-1:0] sample_cnt_reg;
    logic                     done_reg;
    logic                     drop_err_reg;

    logic                     start_accept;
    logic                     sample_accept;
    logic                     last_sample;
    logic [1:0]               bin_sel;
    logic [3:0]               bin_en;
    logic [COUNTER_WIDTH-1:0] bin_count [4];

    assign start_accept  = (state_reg == ST_IDLE) && start_compress;
    assign sample_accept = (state_reg == ST_ACCUM) && valid_in;
    assign last_sample   = sample_accept && (sample_cnt_reg == LAST_IDX);
    assign bin_sel       = {stream_a, stream_b};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_bin
            assign bin_en[gi] = sample_accept && (bin_sel == 2'(gi));

            hist_bin_counter #(
                .COUNTER_WIDTH(COUNTER_WIDTH)
            ) u_bin (
                .clk   (clk),
                .rst   (rst),
                .clear (start_accept),
                .enable(bin_en[gi]),
                .count (bin_count[gi])
            );
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (start_compress) state_next = ST_ACCUM;
            ST_ACCUM: if (last_sample)    state_next = ST_HOLD;
            ST_HOLD:  if (hist_ready)     state_next = ST_IDLE;
            default:                      state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            sample_cnt_reg <= '0;
            done_reg       <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= (state_reg == ST_HOLD) && hist_ready;
            if (start_accept) begin
                sample_cnt_reg <= '0;
            end else if (sample_accept) begin
                sample_cnt_reg <= sample_cnt_reg + COUNTER_WIDTH'(1);
            end
        end
    end

    // A sample offered outside ACCUM is lost; the start that opens a new
    // histogram takes precedence and leaves the flag clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_err_reg <= 1'b0;
        end else if (start_accept) begin
            drop_err_reg <= 1'b0;
        end else if (valid_in && (state_reg != ST_ACCUM)) begin
            drop_err_reg <= 1'b1;
        end
    end

    assign count_00      = bin_count[BIN_00];
    assign count_01      = bin_count[BIN_01];
    assign count_10      = bin_count[BIN_10];
    assign count_11      = bin_count[BIN_11];
    assign hist_valid    = (state_reg == ST_HOLD);
    assign busy          = (state_reg != ST_IDLE);
    assign compress_done = done_reg;
    assign drop_err      = drop_err_reg;

endmodule

// File: tb/tb_histogram_compressor.sv
// Directed bench for histogram_compressor with STREAM_LENGTH=8: the driver
// queues expected histograms, a monitor checks them while hist_valid is high.
module tb_histogram_compressor;

    localparam int SL = 8;
    localparam int CW = 4;

    typedef struct {
        int c [4];
    } hist_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_compress = 1'b0;
    logic          stream_a = 1'b0;
    logic          stream_b = 1'b0;
    logic          valid_in = 1'b0;
    logic          hist_ready = 1'b0;
    logic [CW-1:0] count_00;
    logic [CW-1:0] count_01;
    logic [CW-1:0] count_10;
    logic [CW-1:0] count_11;
    logic          hist_valid;
    logic          compress_done;
    logic          busy;
    logic          drop_err;

    int    n_cmp = 0;
    int    n_err = 0;
    hist_t exp_q [$];
    hist_t cur;
    bit    in_hold = 1'b0;
    int    holds_seen = 0;

    histogram_compressor #(
        .STREAM_LENGTH(SL),
        .COUNTER_WIDTH(CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_compress(start_compress),
        .stream_a     (stream_a),
        .stream_b     (stream_b),
        .valid_in     (valid_in),
        .count_00     (count_00),
        .count_01     (count_01),
        .count_10     (count_10),
        .count_11     (count_11),
        .hist_valid   (hist_valid),
        .hist_ready   (hist_ready),
        .compress_done(compress_done),
        .busy         (busy),
        .drop_err     (drop_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic hist_t mk(input int c0, input int c1, input int c2, input int c3);
        hist_t h;
        h.c[0] = c0; h.c[1] = c1; h.c[2] = c2; h.c[3] = c3;
        return h;
    endfunction

    // Monitor: grabs the next expected histogram when hist_valid rises and
    // requires the counts to match it on every cycle of HOLD.
    always @(negedge clk) begin
        if (!rst) begin
            if (hist_valid && !in_hold) begin
                in_hold = 1'b1;
                holds_seen++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_hist_valid", 1, 0);
                    cur = mk(-1, -1, -1, -1);
                end else begin
                    cur = exp_q.pop_front();
                    $display("hist #%0d: counts %0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d",
                             holds_seen, count_00, count_01, count_10, count_11,
                             cur.c[0], cur.c[1], cur.c[2], cur.c[3]);
                end
            end
            if (hist_valid) begin
                chk("count_00", int'(count_00), cur.c[0]);
                chk("count_01", int'(count_01), cur.c[1]);
                chk("count_10", int'(count_10), cur.c[2]);
                chk("count_11", int'(count_11), cur.c[3]);
            end else begin
                in_hold = 1'b0;
            end
        end
    end

    // All driver tasks are entered and left at a falling edge.
    task automatic pair(input logic a, input logic b);
        valid_in = 1'b1;
        stream_a = a;
        stream_b = b;
        @(negedge clk);
        valid_in = 1'b0;
    endtask

    task automatic start();
        start_compress = 1'b1;
        @(negedge clk);
        start_compress = 1'b0;
        chk("busy_after_start", int'(busy), 1);
        chk("drop_err_after_start", int'(drop_err), 0);
        chk("sum_after_start", int'(count_00) + int'(count_01) + int'(count_10) + int'(count_11), 0);
    endtask

    task automatic handshake(input int wait_cycles, input hist_t h);
        for (int i = 0; i < wait_cycles; i++) begin
            chk("hist_valid_waiting", int'(hist_valid), 1);
            @(negedge clk);
        end
        hist_ready = 1'b1;
        @(negedge clk);
        hist_ready = 1'b0;
        chk("hist_valid_after_ready", int'(hist_valid), 0);
        chk("compress_done_pulse", int'(compress_done), 1);
        chk("busy_idle", int'(busy), 0);
        @(negedge clk);
        chk("compress_done_width", int'(compress_done), 0);
        chk("idle_count_00", int'(count_00), h.c[0]);
        chk("idle_count_11", int'(count_11), h.c[3]);
    endtask

    initial begin
        hist_t h;
        logic [1:0] vec [8];
        int loop_cnt [4];

        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst_hist_valid", int'(hist_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_drop_err", int'(drop_err), 0);
        chk("rst_compress_done", int'(compress_done), 0);
        chk("rst_counts", int'(count_00) + int'(count_01) + int'(count_10) + int'(count_11), 0);

        // Balanced stream, back-to-back samples
        vec = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00};
        h = mk(2, 2, 2, 2);
        exp_q.push_back(h);
        start();
        for (int i = 0; i < SL; i++) begin
            chk("hist_valid_early", int'(hist_valid), 0);
            pair(vec[i][1], vec[i][0]);
        end
        chk("hist_valid_latency", int'(hist_valid), 1);
        handshake(0, h);

        // All 11 with 3-cycle gaps, then a 5-cycle ready stall
        h = mk(0, 0, 0, 8);
        exp_q.push_back(h);
        start();
        for (int i = 0; i < SL; i++) begin
            pair(1'b1, 1'b1);
            if (i != SL - 1) begin
                for (int g = 0; g < 3; g++) begin
                    chk("busy_gap", int'(busy), 1);
                    @(negedge clk);
                end
            end
        end
        chk("hist_valid_gapped", int'(hist_valid), 1);
        handshake(5, h);

        // Drop in IDLE, restart attempt and stray ready in ACCUM, drop in HOLD
        valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        chk("drop_err_idle", int'(drop_err), 1);
        h = mk(0, 3, 5, 0);
        exp_q.push_back(h);
        start();
        for (int i = 0; i < 3; i++) pair(1'b0, 1'b1);
        start_compress = 1'b1;
        hist_ready = 1'b1;
        @(negedge clk);
        start_compress = 1'b0;
        hist_ready = 1'b0;
        chk("busy_ignored_start", int'(busy), 1);
        chk("count_01_ignored_start", int'(count_01), 3);
        chk("sum_ignored_start", int'(count_00) + int'(count_01) + int'(count_10) + int'(count_11), 3);
        chk("done_stray_ready", int'(compress_done), 0);
        for (int i = 0; i < 5; i++) pair(1'b1, 1'b0);
        chk("hist_valid_after_restart_try", int'(hist_valid), 1);
        valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        chk("drop_err_hold", int'(drop_err), 1);
        chk("hist_valid_after_drop", int'(hist_valid), 1);
        handshake(0, h);

        // Reset mid-ACCUM discards everything at once
        start();
        for (int i = 0; i < 5; i++) pair(1'b1, 1'b0);
        rst = 1'b1;
        #1;
        chk("mid_rst_count_10", int'(count_10), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_hist_valid", int'(hist_valid), 0);
        chk("mid_rst_done", int'(compress_done), 0);
        chk("mid_rst_drop_err", int'(drop_err), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_done", int'(compress_done), 0);
        h = mk(0, 0, 8, 0);
        exp_q.push_back(h);
        start();
        for (int i = 0; i < SL; i++) pair(1'b1, 1'b0);
        handshake(1, h);

        // Loopback: expand counts 3/1/0/4 into a stream, recompress
        loop_cnt = '{3, 1, 0, 4};
        h = mk(3, 1, 0, 4);
        exp_q.push_back(h);
        start();
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < loop_cnt[b]; k++) pair(b[1], b[0]);
        end
        chk("hist_valid_loopback", int'(hist_valid), 1);
        handshake(2, h);

        chk("holds_seen", holds_seen, 5);
        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
